// File: rtl/regalu_pkg.sv
// Shared opcodes, flag bit positions, FSM states and control-word field helpers.
package regalu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_NOP  = 5'd0;
  localparam logic [OP_W-1:0] OP_LOAD = 5'd1;
  localparam logic [OP_W-1:0] OP_MOV  = 5'd2;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OP_W-1:0] OP_AND  = 5'd5;
  localparam logic [OP_W-1:0] OP_OR   = 5'd6;
  localparam logic [OP_W-1:0] OP_XOR  = 5'd7;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd8;
  localparam logic [OP_W-1:0] OP_SHL  = 5'd9;
  localparam logic [OP_W-1:0] OP_SHR  = 5'd10;
  localparam logic [OP_W-1:0] OP_ADC  = 5'd11;
  localparam logic [OP_W-1:0] OP_CMP  = 5'd12;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd13;

  // flags port is {V, C, N, Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // register-address fields sit above the opcode: slot 0 = dst, 1 = src_b, 2 = src_a
  localparam int SLOT_DST  = 0;
  localparam int SLOT_SRCB = 1;
  localparam int SLOT_SRCA = 2;

  typedef enum logic {IDLE_RUN, MUL_BUSY} state_t;

  function automatic int reg_field_lsb(input int reg_aw, input int slot);
    return OP_W + slot * reg_aw;
  endfunction

  function automatic int ctrl_width(input int reg_aw);
    return 3 * reg_aw + OP_W;
  endfunction

endpackage

// File: rtl/regalu_alu_core.sv
// Single-cycle combinational ALU covering every opcode except MUL.
module regalu_alu_core
  import regalu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags,
  output logic              wr_en,
  output logic              res_en
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] ext;
  logic            c;
  logic            v;

  // result, carry/borrow, overflow and write/report qualifiers per opcode
  always_comb begin
    ext    = '0;
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    wr_en  = 1'b0;
    res_en = 1'b1;
    case (op)
      OP_LOAD, OP_MOV: begin
        result = a;
        wr_en  = 1'b1;
      end
      OP_ADD, OP_ADC: begin
        ext    = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, (op == OP_ADC) & c_in};
        result = ext[MSB:0];
        c      = ext[DATA_W];
        v      = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
        wr_en  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        // ext[DATA_W] is the borrow out of the subtraction
        ext    = {1'b0, a} - {1'b0, b};
        result = ext[MSB:0];
        c      = ext[DATA_W];
        v      = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
        wr_en  = (op == OP_SUB);
      end
      OP_AND: begin result = a & b; wr_en = 1'b1; end
      OP_OR:  begin result = a | b; wr_en = 1'b1; end
      OP_XOR: begin result = a ^ b; wr_en = 1'b1; end
      OP_NOT: begin result = ~a;    wr_en = 1'b1; end
      OP_SHL: begin
        result = {a[MSB-1:0], 1'b0};
        c      = a[MSB];
        wr_en  = 1'b1;
      end
      OP_SHR: begin
        result = {1'b0, a[MSB:1]};
        c      = a[0];
        wr_en  = 1'b1;
      end
      default: res_en = 1'b0;
    endcase
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[MSB];
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/regfile_alu_pipe.sv
// Register file + two-stage ALU pipeline with an iterative shift-add multiplier.
//
// state    | meaning
// IDLE_RUN | accepting control words, single-cycle ops flow through stage 2
// MUL_BUSY | shift-add multiply iterating, ctrl_ready low
module regfile_alu_pipe
  import regalu_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int REG_AW = 3,
  localparam int CTRL_W = ctrl_width(REG_AW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic [CTRL_W-1:0] control,
  input  logic              ctrl_valid,
  output logic              ctrl_ready,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic [3:0]        flags
);

  localparam int NREG  = 2 ** REG_AW;
  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] regs [NREG];

  logic [REG_AW-1:0] src_a, src_b, dst;
  logic [OP_W-1:0]   op;
  logic              accept;
  logic [DATA_W-1:0] opa, opb;

  logic              s2_valid;
  logic [OP_W-1:0]   s2_op;
  logic [REG_AW-1:0] s2_dst;
  logic [DATA_W-1:0] s2_a, s2_b;

  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flags;
  logic              alu_wr, alu_en;

  logic              wb_fire, wb_wr;
  logic [DATA_W-1:0] wb_res;
  logic [3:0]        wb_flags;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  mul_cnt;
  logic [DATA_W-1:0] mul_acc, mul_mcand, mul_mplier, mul_acc_nx;
  logic [REG_AW-1:0] mul_dst;

  assign op     = control[OP_W-1:0];
  assign dst    = control[reg_field_lsb(REG_AW, SLOT_DST)  +: REG_AW];
  assign src_b  = control[reg_field_lsb(REG_AW, SLOT_SRCB) +: REG_AW];
  assign src_a  = control[reg_field_lsb(REG_AW, SLOT_SRCA) +: REG_AW];
  assign accept = ctrl_valid && ctrl_ready;

  assign mul_acc_nx = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  regalu_alu_core #(.DATA_W(DATA_W)) u_alu (
    .a      (s2_a),
    .b      (s2_b),
    .op     (s2_op),
    .c_in   (flags[FLAG_C]),
    .result (alu_res),
    .flags  (alu_flags),
    .wr_en  (alu_wr),
    .res_en (alu_en)
  );

  // stage-2 writeback selection; a finished multiply rides stage 2 with its product in s2_a
  always_comb begin
    wb_fire  = 1'b0;
    wb_wr    = 1'b0;
    wb_res   = alu_res;
    wb_flags = alu_flags;
    if (s2_valid) begin
      if (s2_op == OP_MUL) begin
        wb_fire          = 1'b1;
        wb_wr            = 1'b1;
        wb_res           = s2_a;
        wb_flags         = '0;
        wb_flags[FLAG_Z] = (s2_a == '0);
        wb_flags[FLAG_N] = s2_a[DATA_W-1];
      end else begin
        wb_fire = alu_en;
        wb_wr   = alu_wr;
      end
    end
  end

  // operand read with bypass of the value being written back at this same edge
  always_comb begin
    opa = regs[src_a];
    opb = regs[src_b];
    if (wb_wr && (s2_dst == src_a)) opa = wb_res;
    if (wb_wr && (s2_dst == src_b)) opb = wb_res;
  end

  // FSM next state and ready
  always_comb begin
    state_nx   = state;
    ctrl_ready = (state == IDLE_RUN);
    case (state)
      IDLE_RUN: if (accept && (op == OP_MUL)) state_nx = MUL_BUSY;
      MUL_BUSY: if (mul_cnt == '0) state_nx = IDLE_RUN;
      default:  state_nx = IDLE_RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE_RUN;
    else        state <= state_nx;
  end

  // register file, outputs, stage 2 and multiplier iteration
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      out        <= '0;
      flags      <= '0;
      out_valid  <= 1'b0;
      s2_valid   <= 1'b0;
      s2_op      <= OP_NOP;
      s2_dst     <= '0;
      s2_a       <= '0;
      s2_b       <= '0;
      mul_cnt    <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_dst    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (wb_fire) begin
        out_valid <= 1'b1;
        flags     <= wb_flags;
        if (wb_wr) begin
          regs[s2_dst] <= wb_res;
          out          <= wb_res;
        end
      end
      s2_valid <= 1'b0;
      if (accept) begin
        s2_op  <= op;
        s2_dst <= dst;
        s2_a   <= (op == OP_LOAD) ? in : opa;
        s2_b   <= opb;
        if (op == OP_MUL) begin
          mul_acc    <= '0;
          mul_mcand  <= opa;
          mul_mplier <= opb;
          mul_cnt    <= CNT_W'(DATA_W - 1);
          mul_dst    <= dst;
        end else begin
          s2_valid <= 1'b1;
        end
      end else if (state == MUL_BUSY) begin
        mul_acc    <= mul_acc_nx;
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        mul_cnt    <= mul_cnt - 1'b1;
        if (mul_cnt == '0) begin
          s2_valid <= 1'b1;
          s2_op    <= OP_MUL;
          s2_dst   <= mul_dst;
          s2_a     <= mul_acc_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Scoreboard bench: stimulus pushes expected {out, flags}; monitor pops on each out_valid.
module tb_regfile_alu_pipe;
  import regalu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic [13:0] control;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic [7:0]  dout;
  logic        out_valid;
  logic [3:0]  flags;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int cyc = 0;
  int last_pulse_cyc = 0;
  int add_cyc, mul_cyc, busy;
  logic [11:0] sbq[$];

  regfile_alu_pipe #(.DATA_W(8), .REG_AW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (din),
    .control    (control),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .out        (dout),
    .out_valid  (out_valid),
    .flags      (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] pack(input logic [4:0] op, input int a, input int b, input int d);
    return {3'(a), 3'(b), 3'(d), op};
  endfunction

  task automatic push(input logic [7:0] o, input logic [3:0] f);
    sbq.push_back({o, f});
    exp_pulses++;
  endtask

  // drives one control word across exactly one rising edge (call at a falling edge)
  task automatic send(input logic [4:0] op, input int a, input int b, input int d, input logic [7:0] v);
    control    = pack(op, a, b, d);
    din        = v;
    ctrl_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    ctrl_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // monitor
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        pulses++;
        last_pulse_cyc = cyc;
        check("pulse_expected", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("out", dout, e[11:4]);
          check("flags", flags, e[3:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; ctrl_valid = 1'b0; control = '0; din = '0;
    repeat (3) @(negedge clk);
    check("reset_out", dout, 0);
    check("reset_flags", flags, 0);
    check("reset_out_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", ctrl_ready, 1);

    // back-to-back loads then a dependent ADD through the bypass
    push(8'h08, 4'b0000); send(OP_LOAD, 0, 0, 1, 8'h08);
    push(8'h0A, 4'b0000); send(OP_LOAD, 0, 0, 2, 8'h0A);
    push(8'h12, 4'b0000); add_cyc = cyc + 1; send(OP_ADD, 2, 1, 3, 8'h00);
    idle(3);
    check("add_latency", last_pulse_cyc - add_cyc, 1);

    // signed overflow on SUB, CMP keeps out
    push(8'h80, 4'b0010); send(OP_LOAD, 0, 0, 1, 8'h80);
    push(8'h01, 4'b0000); send(OP_LOAD, 0, 0, 2, 8'h01);
    push(8'h7F, 4'b1000); send(OP_SUB, 1, 2, 5, 8'h00);
    push(8'h7F, 4'b1000); send(OP_CMP, 1, 2, 6, 8'h00);
    push(8'h7F, 4'b0000); send(OP_MOV, 5, 0, 6, 8'h00);
    idle(3);

    // ADD carry out then ADC consuming it
    push(8'hFF, 4'b0010); send(OP_LOAD, 0, 0, 1, 8'hFF);
    push(8'h01, 4'b0000); send(OP_LOAD, 0, 0, 2, 8'h01);
    push(8'h00, 4'b0101); send(OP_ADD, 1, 2, 1, 8'h00);
    push(8'h02, 4'b0000); send(OP_ADC, 1, 2, 1, 8'h00);
    idle(3);

    // remaining single-cycle ops, r1=0x02 r2=0x01
    push(8'h04, 4'b0000); send(OP_SHL, 1, 0, 7, 8'h00);
    push(8'h00, 4'b0101); send(OP_SHR, 2, 0, 7, 8'h00);
    push(8'hFE, 4'b0010); send(OP_NOT, 2, 0, 7, 8'h00);
    push(8'h00, 4'b0001); send(OP_AND, 1, 2, 7, 8'h00);
    push(8'h03, 4'b0000); send(OP_OR,  1, 2, 7, 8'h00);
    push(8'h03, 4'b0000); send(OP_XOR, 1, 2, 7, 8'h00);
    push(8'hFF, 4'b0110); send(OP_SUB, 2, 1, 7, 8'h00);
    idle(3);

    // multiply with an ADD offered while busy
    push(8'h0C, 4'b0000); send(OP_LOAD, 0, 0, 1, 8'h0C);
    push(8'h0B, 4'b0000); send(OP_LOAD, 0, 0, 2, 8'h0B);
    idle(2);
    push(8'h84, 4'b0010); mul_cyc = cyc + 1; send(OP_MUL, 1, 2, 4, 8'h00);
    control = pack(OP_ADD, 1, 2, 4); ctrl_valid = 1'b1; busy = 0;
    for (int i = 0; i < 20 && !ctrl_ready; i++) begin
      busy++;
      if (busy == 3) ctrl_valid = 1'b0;
      @(negedge clk);
    end
    ctrl_valid = 1'b0;
    check("mul_busy_cycles", busy, 8);
    idle(3);
    check("mul_latency", last_pulse_cyc - mul_cyc, 9);
    push(8'h84, 4'b0010); send(OP_MOV, 4, 0, 0, 8'h00);
    idle(3);

    // reset 3 cycles into a multiply
    send(OP_MUL, 1, 2, 5, 8'h00);
    idle(3);
    rst_n = 1'b0;
    idle(2);
    check("abort_out", dout, 0);
    check("abort_flags", flags, 0);
    check("abort_out_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", ctrl_ready, 1);
    push(8'h00, 4'b0001); send(OP_MOV, 4, 0, 0, 8'h00);
    push(8'h00, 4'b0001); send(OP_MOV, 1, 0, 0, 8'h00);
    idle(3);

    // undefined opcode and NOP are inert
    push(8'h55, 4'b0000); send(OP_LOAD, 0, 0, 1, 8'h55);
    idle(2);
    send(5'd20, 1, 1, 1, 8'hAA);
    send(OP_NOP, 1, 1, 1, 8'hAA);
    idle(3);
    check("undef_out", dout, 8'h55);
    check("undef_flags", flags, 4'b0000);
    push(8'h55, 4'b0000); send(OP_MOV, 1, 0, 2, 8'h00);
    idle(5);

    check("queue_drained", sbq.size(), 0);
    check("pulse_count", pulses, exp_pulses);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_alu_pipe.md
REGFILE_ALU_PIPE -- requirements
Module: regfile_alu_pipe

Interface
REQ-001 Parameter: DATA_W, default 8, datapath and register width (min 4).
REQ-002 Parameter: REG_AW, default 3, register address width; 2**REG_AW registers.
REQ-003 Parameter: CTRL_W, derived, 3*REG_AW+5; not overridable.
REQ-004 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst_n  in  1  synchronous, active-low reset.
REQ-006 Port: in  in  DATA_W  external operand for LOAD.
REQ-007 Port: control  in  CTRL_W  {src_a[REG_AW], src_b[REG_AW], dst[REG_AW], op[5]}, MSB first.
REQ-008 Port: ctrl_valid  in  1  control word present.
REQ-009 Port: ctrl_ready  out  1  block accepts a control word this cycle.
REQ-010 Port: out  out  DATA_W  last result.
REQ-011 Port: out_valid  out  1  one-cycle pulse; out/flags updated.
REQ-012 Port: flags  out  4  {V, C, N, Z}.

Function
REQ-013 Accept = ctrl_valid && ctrl_ready at a rising edge; control and in are sampled at that edge only.
REQ-014 Opcodes: 0 NOP, 1 LOAD (dst<=in), 2 MOV (dst<=A), 3 ADD, 4 SUB (A-B), 5 AND, 6 OR, 7 XOR, 8 NOT A, 9 SHL A by 1, 10 SHR A (logical) by 1, 11 ADC (A+B+C), 12 CMP (A-B, flags only, no write), 13 MUL (low DATA_W bits of A*B); 14-31 behave as NOP.
REQ-015 Two-stage pipeline: accept edge E0 latches operands A=R[src_a], B=R[src_b]; edge E1 writes R[dst], out, flags, and out_valid high for the cycle after E1; latency 1 edge after accept for all ops except MUL.
REQ-016 Operand read at E0 shall bypass the value written by the preceding instruction at the same edge (back-to-back dependency yields the new value).
REQ-017 NOP and opcodes 14-31 produce no register write, no out change, no out_valid pulse.
REQ-018 Flags: Z = result==0, N = result MSB; C = carry-out for ADD/ADC, borrow (1 = borrow) for SUB/CMP, shifted-out bit for SHL/SHR; V = signed overflow for ADD/ADC/SUB/CMP; C,V = 0 for all other ops; LOAD/MOV also update Z,N.
REQ-019 CMP asserts out_valid, updates flags, leaves out and registers unchanged.
REQ-020 Arithmetic is modulo 2**DATA_W; no saturation.
REQ-021 FSM states IDLE_RUN, MUL_BUSY; IDLE_RUN -> MUL_BUSY on MUL accept; MUL_BUSY -> IDLE_RUN after DATA_W shift-add iterations.
REQ-022 MUL: ctrl_ready low from the edge after accept for exactly DATA_W cycles; result, out_valid pulse, and Z/N (C=V=0) follow DATA_W+1 edges after accept.
REQ-023 ctrl_ready is high in IDLE_RUN; words offered while ctrl_ready is low are ignored, not queued.
REQ-024 Writes to the same dst on consecutive accepts: the later write wins.

Reset
REQ-025 While rst_n=0 at a rising edge: all registers 0, out 0, flags 0, out_valid 0, FSM IDLE_RUN, pipeline stage empty.
REQ-026 ctrl_ready is 1 on the first edge with rst_n=1.
REQ-027 Reset during MUL_BUSY or with an instruction in stage 2 aborts it: no writeback, no out_valid pulse.

Structure
REQ-028 Package regalu_pkg holds opcode constants, flag bit indices, and control field offset functions of REG_AW.
REQ-029 Combinational ALU (all ops except MUL) lives in sub-module regalu_alu_core; register file, bypass, FSM, and MUL iteration stay in regfile_alu_pipe.

Verification (DATA_W=8, REG_AW=3)
REQ-030 LOAD r1<=0x08, LOAD r2<=0x0A back-to-back, then ADD src_a=2,src_b=1,dst=3 -> out 0x12, Z=0,C=0, one out_valid pulse per instruction, bypass exercised.
REQ-031 r1=0x80, r2=0x01, SUB a=1,b=2 -> out 0x7F, V=1, C=0, N=0; CMP same operands -> flags equal, out unchanged.
REQ-032 r1=0xFF, r2=0x01, ADD then ADC -> 0x00 {Z=1,C=1}, then 0x02 {C=0}.
REQ-033 r1=0x0C, r2=0x0B, MUL dst=4 -> ctrl_ready low 8 cycles, out 0x84, C=0, V=0, one pulse; an ADD offered during busy is ignored.
REQ-034 Reset asserted 3 cycles into MUL -> all registers/out/flags 0, no out_valid pulse, ctrl_ready 1 after release.
REQ-035 Opcode 20 with ctrl_valid -> no register, out, flags, or out_valid change.
